// File: rtl/mlp_ctrl_pkg.sv
// Shared types and default widths for the MLP inference sequencer.
// The REDUNDANT_EVAL_EN build uses the FLUSH and SETTLE2 states.
package mlp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE1 = 3'd1,
        FLUSH   = 3'd2,
        SETTLE2 = 3'd3,
        OUT     = 3'd4
    } mlp_state_e;

    localparam int unsigned MLP_IN_W     = 28;
    localparam int unsigned MLP_CLS_W    = 2;
    localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter. Done is high while the count is 1, so the
// owner acts on the edge that finishes the last settle cycle.
module settle_timer
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = SETTLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/mlp_infer_seq.sv
// Valid/ready sequencer around a combinational MLP core: latch, settle, capture.
// Define REDUNDANT_EVAL_EN to re-evaluate each sample and flag mismatches.
module mlp_infer_seq
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned IN_W       = MLP_IN_W,
    parameter int unsigned CLS_W      = MLP_CLS_W,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [IN_W-1:0]  core_inp,
    input  logic [CLS_W-1:0] core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic             out_fault,
    output logic             fault_sticky,
    output logic             busy,
    output logic [CNT_W-1:0] infer_count
);

    localparam logic [SETTLE_CNT_W-1:0] SettleLoad = SETTLE_CNT_W'(SETTLE_CYC);

    mlp_state_e       r_state, w_state_d;
    logic [IN_W-1:0]  r_core_inp, w_core_inp_d;
    logic             r_out_valid, w_out_valid_d;
    logic [CLS_W-1:0] r_out_class, w_out_class_d;
    logic             r_out_fault, w_out_fault_d;
    logic             r_fault_sticky, w_fault_sticky_d;
    logic [CNT_W-1:0] r_infer_count, w_infer_count_d;
    logic             w_accept, w_load, w_dec, w_done;

    assign in_ready = (r_state == IDLE) || ((r_state == OUT) && out_ready);
    assign w_accept = in_valid && in_ready;

    settle_timer #(
        .CNT_W (SETTLE_CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (SettleLoad),
        .i_dec      (w_dec),
        .o_done     (w_done)
    );

`ifdef REDUNDANT_EVAL_EN
    logic [IN_W-1:0] r_shadow, w_shadow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= w_shadow_d;
        end
    end
`endif

    always_comb begin
        w_state_d        = r_state;
        w_core_inp_d     = r_core_inp;
        w_out_valid_d    = r_out_valid;
        w_out_class_d    = r_out_class;
        w_out_fault_d    = r_out_fault;
        w_fault_sticky_d = r_fault_sticky;
        w_infer_count_d  = r_infer_count;
        w_load           = 1'b0;
        w_dec            = 1'b0;
`ifdef REDUNDANT_EVAL_EN
        w_shadow_d       = r_shadow;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_core_inp_d = in_data;
                    w_load       = 1'b1;
                    w_state_d    = SETTLE1;
`ifdef REDUNDANT_EVAL_EN
                    w_shadow_d   = in_data;
`endif
                end
            end
            SETTLE1: begin
                w_dec = 1'b1;
                if (w_done) begin
                    w_out_class_d = core_out;
`ifdef REDUNDANT_EVAL_EN
                    // Drive zeros for a cycle so the second pass starts from a fresh input.
                    w_core_inp_d  = '0;
                    w_state_d     = FLUSH;
`else
                    w_out_valid_d = 1'b1;
                    w_state_d     = OUT;
`endif
                end
            end
`ifdef REDUNDANT_EVAL_EN
            FLUSH: begin
                w_core_inp_d = r_shadow;
                w_load       = 1'b1;
                w_state_d    = SETTLE2;
            end
            SETTLE2: begin
                w_dec = 1'b1;
                if (w_done) begin
                    w_out_fault_d    = (core_out != r_out_class);
                    w_fault_sticky_d = r_fault_sticky | (core_out != r_out_class);
                    w_out_valid_d    = 1'b1;
                    w_state_d        = OUT;
                end
            end
`endif
            OUT: begin
                if (out_ready) begin
                    w_infer_count_d = r_infer_count + 1'b1;
                    w_out_valid_d   = 1'b0;
                    if (w_accept) begin
                        w_core_inp_d = in_data;
                        w_load       = 1'b1;
                        w_state_d    = SETTLE1;
`ifdef REDUNDANT_EVAL_EN
                        w_shadow_d   = in_data;
`endif
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_out_valid_d = 1'b0;
                w_state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_core_inp     <= '0;
            r_out_valid    <= 1'b0;
            r_out_class    <= '0;
            r_out_fault    <= 1'b0;
            r_fault_sticky <= 1'b0;
            r_infer_count  <= '0;
        end else begin
            r_state        <= w_state_d;
            r_core_inp     <= w_core_inp_d;
            r_out_valid    <= w_out_valid_d;
            r_out_class    <= w_out_class_d;
            r_out_fault    <= w_out_fault_d;
            r_fault_sticky <= w_fault_sticky_d;
            r_infer_count  <= w_infer_count_d;
        end
    end

    assign core_inp     = r_core_inp;
    assign out_valid    = r_out_valid;
    assign out_class    = r_out_class;
    assign busy         = (r_state != IDLE);
    assign infer_count  = r_infer_count;
`ifdef REDUNDANT_EVAL_EN
    assign out_fault    = r_out_fault;
    assign fault_sticky = r_fault_sticky;
`else
    assign out_fault    = 1'b0;
    assign fault_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_infer_seq.sv
// Randomized bench for mlp_infer_seq against a cycle-count transaction model.
// Honours REDUNDANT_EVAL_EN for latency and fault-injection expectations.
module tb_mlp_infer_seq;

    localparam int unsigned S   = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned IW  = 28;
`ifdef REDUNDANT_EVAL_EN
    localparam int          LAT = 2 * S + 1;
`else
    localparam int          LAT = S;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [IW-1:0] core_inp;
    logic [1:0]    core_out;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_class;
    logic          out_fault;
    logic          fault_sticky;
    logic          busy;
    logic [CW-1:0] infer_count;
    logic          inj;

    always #5 clk = ~clk;

    mlp_infer_seq #(
        .IN_W       (IW),
        .CLS_W      (2),
        .SETTLE_CYC (S),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .core_inp     (core_inp),
        .core_out     (core_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_fault    (out_fault),
        .fault_sticky (fault_sticky),
        .busy         (busy),
        .infer_count  (infer_count)
    );

    // Stand-in core: parity of the two feature halves.
    function automatic logic [1:0] core_f(input logic [IW-1:0] x);
        return {^x[13:0], ^x[27:14]};
    endfunction

    assign core_out = core_f(core_inp) ^ (inj ? 2'b11 : 2'b00);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one sample in flight, result due LAT edges after accept.
    int            cyc = 0;
    int            m_acc = 0;
    bit            m_inflight = 0;
    logic [1:0]    m_cls = '0, m_prev = '0;
    logic [CW-1:0] m_cnt = '0;
    logic [IW-1:0] m_core = '0;
    bit            m_inj_cur = 0, m_prev_fault = 0, m_sticky = 0;
    bit            inj_req = 0;

    task automatic model_reset();
        m_inflight   = 0;
        m_cls        = '0;
        m_prev       = '0;
        m_cnt        = '0;
        m_core       = '0;
        m_inj_cur    = 0;
        m_prev_fault = 0;
        m_sticky     = 0;
        inj          = 1'b0;
    endtask

    task automatic step();
        bit exp_ov, exp_ir, acc, hs;
        @(negedge clk);
        exp_ov = m_inflight && (cyc - m_acc >= LAT);
        exp_ir = !m_inflight || (exp_ov && out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("busy", 32'(busy), 32'(m_inflight));
        chk("out_class", 32'(out_class), 32'(exp_ov ? m_cls : m_prev));
        chk("out_fault", 32'(out_fault), 32'(exp_ov ? m_inj_cur : m_prev_fault));
        chk("fault_sticky", 32'(fault_sticky), 32'(m_sticky | (exp_ov & m_inj_cur)));
        chk("infer_count", 32'(infer_count), 32'(m_cnt));
`ifndef REDUNDANT_EVAL_EN
        chk("core_inp", 32'(core_inp), 32'(m_core));
`endif
        acc = in_valid && exp_ir;
        hs  = exp_ov && out_ready;
        if (hs) begin
            m_cnt        = m_cnt + 1'b1;
            m_inflight   = 0;
            m_prev       = m_cls;
            m_prev_fault = m_inj_cur;
            m_sticky     = m_sticky | m_inj_cur;
        end
        if (acc) begin
            m_inflight = 1;
            m_acc      = cyc + 1;
            m_cls      = core_f(in_data);
            m_core     = in_data;
            m_inj_cur  = inj_req;
        end
        // Corrupt the core only after the first capture (second evaluation window).
        inj = m_inflight && m_inj_cur && (cyc - m_acc >= int'(S));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] d;
        d = IW'($urandom);
        if (d == '0) d = IW'(1);
        return d;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_cls"}, 32'(out_class), 32'd0);
        chk({tag, "_cnt"}, 32'(infer_count), 32'd0);
        chk({tag, "_inp"}, 32'(core_inp), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_flt"}, 32'(out_fault), 32'd0);
        chk({tag, "_stk"}, 32'(fault_sticky), 32'd0);
        chk({tag, "_ir"}, 32'(in_ready), 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        inj       = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();

        // Single directed sample.
        in_valid  = 1'b1;
        in_data   = 28'h8000000;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (LAT + 3) step();
        chk("single_cls", 32'(out_class), 32'd1);

        // Backpressure: result held, second sample waits, then handshake + accept together.
        in_valid  = 1'b1;
        in_data   = rand_data();
        out_ready = 1'b0;
        step();
        in_data = rand_data();
        repeat (LAT + 10) step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (LAT + 3) step();

        // Back-to-back stream of 8 samples.
        in_valid = 1'b1;
        repeat (8 * (LAT + 1)) begin
            in_data = rand_data();
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 3) step();

        // Randomized traffic.
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rand_data();
`ifdef REDUNDANT_EVAL_EN
            inj_req   = ($urandom_range(0, 3) == 0);
`endif
            step();
        end
        inj_req   = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 3) step();

        // Reset during the first settle phase.
        in_valid = 1'b1;
        in_data  = rand_data();
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        release_reset();
        repeat (LAT + 2) step();

        // Counter wrap: 16+ handshakes on a 4-bit counter.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (17 * (LAT + 1)) begin
            in_data = rand_data();
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
